mem_io_bus_arbiter: RTL and testbench

- Shares the single CPU_export memory/IO access port between two requesters: instruction fetch (read-only, memory space) and data access (load/store, memory or IO space).
- Sequences every transaction: drives en/RW/MemIO/addr/data_write for a fixed number of cycles, captures data_read, and returns a one-cycle ack to the winning requester.
- Data port has fixed priority over fetch. A starvation guard forces a fetch grant after a bounded run of consecutive data grants.

---
 rtl/mem_io_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_io_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bus_arbiter.sv
// Two-requester arbiter for the shared CPU memory/IO port: data has priority,
// fetch is protected from starvation by a bounded data-grant streak.
module mem_io_bus_arbiter #(
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic        d_memio,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        bus_en,
    output logic        bus_RW,
    output logic        bus_MemIO,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_data_write,
    input  logic [15:0] bus_data_read,
    output logic        busy
);

    localparam int unsigned CNT_W    = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int unsigned STREAK_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                gnt, gnt_nxt;
    logic                bus_en_nxt, bus_rw_nxt, bus_memio_nxt;
    logic [15:0]         bus_addr_nxt, bus_data_write_nxt;
    logic                f_ack_nxt, d_ack_nxt, busy_nxt;
    logic [15:0]         f_rdata_nxt, d_rdata_nxt;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            streak         <= '0;
            gnt            <= 1'b0;
            bus_en         <= 1'b0;
            bus_RW         <= 1'b0;
            bus_MemIO      <= 1'b0;
            bus_addr       <= '0;
            bus_data_write <= '0;
            f_ack          <= 1'b0;
            d_ack          <= 1'b0;
            f_rdata        <= '0;
            d_rdata        <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            streak         <= streak_nxt;
            gnt            <= gnt_nxt;
            bus_en         <= bus_en_nxt;
            bus_RW         <= bus_rw_nxt;
            bus_MemIO      <= bus_memio_nxt;
            bus_addr       <= bus_addr_nxt;
            bus_data_write <= bus_data_write_nxt;
            f_ack          <= f_ack_nxt;
            d_ack          <= d_ack_nxt;
            f_rdata        <= f_rdata_nxt;
            d_rdata        <= d_rdata_nxt;
            busy           <= busy_nxt;
        end
    end

    // Arbitration, access sequencing and next-output computation
    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        streak_nxt         = streak;
        gnt_nxt            = gnt;
        bus_en_nxt         = bus_en;
        bus_rw_nxt         = bus_RW;
        bus_memio_nxt      = bus_MemIO;
        bus_addr_nxt       = bus_addr;
        bus_data_write_nxt = bus_data_write;
        f_ack_nxt          = 1'b0;
        d_ack_nxt          = 1'b0;
        f_rdata_nxt        = f_rdata;
        d_rdata_nxt        = d_rdata;

        case (state)
            S_IDLE: begin
                if (d_req && (!f_req || (streak < STREAK_W'(STARVE_MAX)))) begin
                    gnt_nxt            = 1'b1;
                    bus_en_nxt         = 1'b1;
                    bus_rw_nxt         = d_rw;
                    bus_memio_nxt      = d_memio;
                    bus_addr_nxt       = d_addr;
                    bus_data_write_nxt = d_wdata;
                    cnt_nxt            = '0;
                    state_nxt          = S_ACCESS;
                    // Granting data past a waiting fetch implies streak < STARVE_MAX,
                    // so the increment saturates naturally at STARVE_MAX.
                    streak_nxt         = f_req ? (streak + STREAK_W'(1)) : '0;
                end else if (f_req) begin
                    gnt_nxt            = 1'b0;
                    bus_en_nxt         = 1'b1;
                    bus_rw_nxt         = 1'b0;
                    bus_memio_nxt      = 1'b0;
                    bus_addr_nxt       = f_addr;
                    bus_data_write_nxt = '0;
                    cnt_nxt            = '0;
                    state_nxt          = S_ACCESS;
                    streak_nxt         = '0;
                end
            end
            S_ACCESS: begin
                if (cnt == CNT_W'(ACC_CYCLES - 1)) begin
                    if (!bus_RW) begin
                        if (gnt) d_rdata_nxt = bus_data_read;
                        else     f_rdata_nxt = bus_data_read;
                    end
                    bus_en_nxt = 1'b0;
                    state_nxt  = S_RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                d_ack_nxt = gnt;
                f_ack_nxt = !gnt;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_mem_io_bus_arbiter.sv
// Directed bench for mem_io_bus_arbiter with a behavioural memory/IO slave.
module tb_mem_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, d_req, d_rw, d_memio;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_ack, d_ack, bus_en, bus_RW, bus_MemIO, busy;
    logic [15:0] f_rdata, d_rdata, bus_addr, bus_data_write, bus_data_read;

    int tests  = 0;
    int failed = 0;

    logic [15:0] mem [256];
    logic [15:0] io  [256];
    logic        preload;

    always #5 clk = ~clk;

    mem_io_bus_arbiter #(.ACC_CYCLES(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_memio(d_memio), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .bus_en(bus_en), .bus_RW(bus_RW), .bus_MemIO(bus_MemIO),
        .bus_addr(bus_addr), .bus_data_write(bus_data_write),
        .bus_data_read(bus_data_read), .busy(busy)
    );

    // Slave: separate memory and IO spaces, 256 words each
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 16'h0000;
                io[i]  <= 16'h0000;
            end
            mem[8'h10] <= 16'hA5A5;
            mem[8'h03] <= 16'hBEEF;
        end else if (bus_en && bus_RW) begin
            if (bus_MemIO) io[bus_addr[7:0]]  <= bus_data_write;
            else           mem[bus_addr[7:0]] <= bus_data_write;
        end
    end

    always_comb bus_data_read = bus_MemIO ? io[bus_addr[7:0]] : mem[bus_addr[7:0]];

    typedef struct {
        logic        f_req;
        logic [15:0] f_addr;
        logic        d_req;
        logic        d_rw;
        logic        d_memio;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        drop;       // requester drops req right after the grant
        logic        exp_data;   // 1: d_ack expected, 0: f_ack expected
        logic        exp_rw;
        logic        exp_memio;
        logic [15:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [15:0] exp_f;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one vector from an idle arbiter and check the whole transaction
    task automatic run_vec(input vec_t v, input int idx);
        int   cyc, en_cnt, busy_cnt, ack_cyc;
        logic got_d, got_f, bus_ok, excl_ok, done;
        string tag;
        tag = $sformatf("v%0d", idx);
        f_req = v.f_req; f_addr = v.f_addr;
        d_req = v.d_req; d_rw = v.d_rw; d_memio = v.d_memio;
        d_addr = v.d_addr; d_wdata = v.d_wdata;
        cyc = -1; en_cnt = 0; busy_cnt = 0; ack_cyc = -1;
        got_d = 1'b0; got_f = 1'b0; bus_ok = 1'b1; excl_ok = 1'b1; done = 1'b0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (v.drop && cyc == 0) begin
                f_req = 1'b0;
                d_req = 1'b0;
            end
            if (bus_en) begin
                en_cnt++;
                if (bus_RW !== v.exp_rw || bus_MemIO !== v.exp_memio ||
                    bus_addr !== v.exp_addr || bus_data_write !== v.exp_wdata)
                    bus_ok = 1'b0;
            end
            if (busy) busy_cnt++;
            if (f_ack && d_ack) excl_ok = 1'b0;
            if (f_ack || d_ack) begin
                got_d = d_ack; got_f = f_ack; ack_cyc = cyc; done = 1'b1;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        check({tag, "_ack_seen"}, 32'(done), 32'd1);
        check({tag, "_ack_port"}, {30'd0, got_d, got_f}, v.exp_data ? 32'd2 : 32'd1);
        check({tag, "_ack_cycle"}, 32'(ack_cyc), 32'd3);
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'd2);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd3);
        check({tag, "_bus_fields"}, 32'(bus_ok), 32'd1);
        check({tag, "_ack_exclusive"}, 32'(excl_ok), 32'd1);
        check({tag, "_f_rdata"}, 32'(f_rdata), 32'(v.exp_f));
        check({tag, "_d_rdata"}, 32'(d_rdata), 32'(v.exp_d));
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, {30'd0, f_ack, d_ack}, 32'd0);
    endtask

    function automatic vec_t mk(
        input logic fr, input logic [15:0] fa, input logic dr, input logic rw,
        input logic mio, input logic [15:0] da, input logic [15:0] dw, input logic drop,
        input logic ed, input logic erw, input logic emio, input logic [15:0] ea,
        input logic [15:0] ew, input logic [15:0] ef, input logic [15:0] edd);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_rw = rw; v.d_memio = mio;
        v.d_addr = da; v.d_wdata = dw; v.drop = drop; v.exp_data = ed;
        v.exp_rw = erw; v.exp_memio = emio; v.exp_addr = ea; v.exp_wdata = ew;
        v.exp_f = ef; v.exp_d = edd;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, d_cyc, f_cyc, n, last;
        logic [9:0] pat;
        logic gap_ok, done, seen;

        rst = 1'b1; preload = 1'b1;
        f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_rw = 1'b0; d_memio = 1'b0;
        d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        check("reset_ctrl", {28'd0, bus_en, f_ack, d_ack, busy}, 32'd0);
        check("reset_rdata", {f_rdata, d_rdata}, 32'd0);
        check("reset_bus", {14'd0, bus_RW, bus_MemIO, bus_addr}, 32'd0);
        check("reset_wdata", 32'(bus_data_write), 32'd0);
        rst = 1'b0;

        //         fr fa        dr rw mio da        dw        drop ed erw emio ea        ew        ef        ed
        vecs[0] = mk(1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0,  0, 0,  0,   16'h0010, 16'h0000, 16'hA5A5, 16'h0000);
        vecs[1] = mk(0, 16'h0000, 1, 1, 0, 16'h0000, 16'hFFFF, 0,  1, 1,  0,   16'h0000, 16'hFFFF, 16'hA5A5, 16'h0000);
        vecs[2] = mk(0, 16'h0000, 1, 0, 0, 16'h0000, 16'h1111, 0,  1, 0,  0,   16'h0000, 16'h1111, 16'hA5A5, 16'hFFFF);
        vecs[3] = mk(0, 16'h0000, 1, 1, 1, 16'h0003, 16'h1234, 0,  1, 1,  1,   16'h0003, 16'h1234, 16'hA5A5, 16'hFFFF);
        vecs[4] = mk(0, 16'h0000, 1, 0, 1, 16'h0003, 16'h0000, 0,  1, 0,  1,   16'h0003, 16'h0000, 16'hA5A5, 16'h1234);
        vecs[5] = mk(0, 16'h0000, 1, 0, 0, 16'h0003, 16'h0000, 0,  1, 0,  0,   16'h0003, 16'h0000, 16'hA5A5, 16'hBEEF);
        vecs[6] = mk(1, 16'h0000, 0, 1, 1, 16'h0003, 16'hDEAD, 0,  0, 0,  0,   16'h0000, 16'h0000, 16'hFFFF, 16'hBEEF);
        vecs[7] = mk(0, 16'h0000, 1, 0, 0, 16'h0010, 16'h0000, 1,  1, 0,  0,   16'h0010, 16'h0000, 16'hFFFF, 16'hA5A5);
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Simultaneous requests: data first, fetch once data drops
        f_req = 1'b1; f_addr = 16'h0010;
        d_req = 1'b1; d_rw = 1'b0; d_memio = 1'b0; d_addr = 16'h0000; d_wdata = '0;
        cyc = -1; d_cyc = -1; f_cyc = -1; done = 1'b0;
        while (!done && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (d_ack) begin d_cyc = cyc; d_req = 1'b0; end
            if (f_ack) begin f_cyc = cyc; f_req = 1'b0; done = 1'b1; end
        end
        f_req = 1'b0; d_req = 1'b0;
        check("simul_d_ack_cycle", 32'(d_cyc), 32'd3);
        check("simul_f_ack_cycle", 32'(f_cyc), 32'd7);
        check("simul_rdata", {f_rdata, d_rdata}, {16'hA5A5, 16'hFFFF});

        // Starvation guard: both held; expect D D D D F D D D D F
        f_req = 1'b1; f_addr = 16'h0000;
        d_req = 1'b1; d_rw = 1'b0; d_memio = 1'b0; d_addr = 16'h0003;
        cyc = -1; n = 0; last = -1; pat = '0; gap_ok = 1'b1;
        while (n < 10 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (f_ack && d_ack) gap_ok = 1'b0;
            if (f_ack || d_ack) begin
                if (cyc - last != 4) gap_ok = 1'b0;
                pat[9 - n] = d_ack;
                last = cyc;
                n++;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        check("starve_ack_count", 32'(n), 32'd10);
        check("starve_pattern", 32'(pat), 32'(10'b11110_11110));
        check("starve_spacing", 32'(gap_ok), 32'd1);
        check("starve_rdata", {f_rdata, d_rdata}, {16'hFFFF, 16'hBEEF});

        // Reset during ACCESS of a data read
        d_req = 1'b1; d_rw = 1'b0; d_memio = 1'b0; d_addr = 16'h0010;
        @(posedge clk); #1;
        check("rst_mid_granted", {31'd0, bus_en}, 32'd1);
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ctrl", {28'd0, bus_en, f_ack, d_ack, busy}, 32'd0);
        check("rst_mid_rdata", {f_rdata, d_rdata}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (f_ack || d_ack || bus_en) seen = 1'b1;
        end
        check("rst_mid_no_ack", 32'(seen), 32'd0);
        run_vec(mk(0, 16'h0000, 1, 0, 0, 16'h0003, 16'h0000, 0,
                   1, 0, 0, 16'h0003, 16'h0000, 16'h0000, 16'hBEEF), 8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
